// File: rtl/conv_row_buffer_writer.sv
// Packs the incoming pixel stream into row-buffer words and spreads
// consecutive image rows round-robin over the three input-row buffers.
module conv_row_buffer_writer #(
  parameter int pixels_in_row = 32,
  parameter int in_pixels     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [15:0]                ix,
  input  logic [15:0]                iy,
  input  logic [15:0]                nif,
  input  logic                       in_valid,
  input  logic [in_pixels*8-1:0]     in_data,
  output logic                       in_ready,
  output logic                       buf1_we,
  output logic                       buf2_we,
  output logic                       buf3_we,
  output logic [15:0]                buf1_adr,
  output logic [15:0]                buf2_adr,
  output logic [15:0]                buf3_adr,
  output logic [pixels_in_row*8-1:0] buf1_din,
  output logic [pixels_in_row*8-1:0] buf2_din,
  output logic [pixels_in_row*8-1:0] buf3_din,
  output logic                       busy,
  output logic                       done
);

  localparam int bw    = in_pixels * 8;
  localparam int ww    = pixels_in_row * 8;
  localparam int lanes = pixels_in_row / in_pixels;
  localparam int lw    = (lanes > 1) ? $clog2(lanes) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0]   ix_q, iy_q, nif_q;
  logic [15:0]   x_cnt, y_cnt, c_cnt;
  logic [lw-1:0] lane;
  logic [ww-1:0] pack;
  logic [2:0]    sel;
  logic [15:0]   ptr   [3];
  logic [2:0]    we_q;
  logic [15:0]   adr_q [3];
  logic [ww-1:0] din_q [3];

  logic          accept;
  logic          go;
  logic          dims_ok;
  logic [15:0]   x_next;
  logic          row_end;
  logic          last_lane;
  logic          last_row;
  logic          last_ch;
  logic          last_beat;
  logic          word_done;
  logic [ww-1:0] next_word;

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state == S_LOAD) || (state == S_DONE);
  assign done      = (state == S_DONE);

  assign accept    = in_valid & in_ready;
  assign go        = (state == S_IDLE) & start;
  assign dims_ok   = (ix != 16'd0) && (iy != 16'd0) && (nif != 16'd0);
  assign x_next    = x_cnt + 16'(in_pixels);
  assign row_end   = (x_next == ix_q);
  assign last_lane = (lane == lw'(lanes - 1));
  assign last_row  = (y_cnt == iy_q - 16'd1);
  assign last_ch   = (c_cnt == nif_q - 16'd1);
  assign last_beat = accept & row_end & last_row & last_ch;
  assign word_done = accept & (row_end | last_lane);

  // pack is cleared after every word, so a short row-end word is zero-padded
  assign next_word = pack | (ww'(in_data) << (lane * bw));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = dims_ok ? S_LOAD : S_DONE;
      S_LOAD: if (last_beat) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ix_q  <= '0;
      iy_q  <= '0;
      nif_q <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
      c_cnt <= '0;
      lane  <= '0;
      pack  <= '0;
      sel   <= 3'b001;
      we_q  <= '0;
      for (int n = 0; n < 3; n++) begin
        ptr[n]   <= '0;
        adr_q[n] <= '0;
        din_q[n] <= '0;
      end
    end else begin
      we_q <= '0;
      if (go) begin
        ix_q  <= ix;
        iy_q  <= iy;
        nif_q <= nif;
        x_cnt <= '0;
        y_cnt <= '0;
        c_cnt <= '0;
        lane  <= '0;
        pack  <= '0;
        sel   <= 3'b001;
        for (int n = 0; n < 3; n++) ptr[n] <= '0;
      end else if (accept) begin
        if (word_done) begin
          pack <= '0;
          lane <= '0;
          for (int n = 0; n < 3; n++) begin
            if (sel[n]) begin
              we_q[n]  <= 1'b1;
              adr_q[n] <= ptr[n];
              din_q[n] <= next_word;
              ptr[n]   <= ptr[n] + 16'd1;
            end
          end
        end else begin
          pack <= next_word;
          lane <= lane + lw'(1);
        end
        if (row_end) begin
          x_cnt <= '0;
          if (last_row) begin
            y_cnt <= '0;
            c_cnt <= c_cnt + 16'd1;
            sel   <= 3'b001;
          end else begin
            y_cnt <= y_cnt + 16'd1;
            sel   <= {sel[1:0], sel[2]};
          end
        end else begin
          x_cnt <= x_next;
        end
      end
    end
  end

  assign buf1_we  = we_q[0];
  assign buf2_we  = we_q[1];
  assign buf3_we  = we_q[2];
  assign buf1_adr = adr_q[0];
  assign buf2_adr = adr_q[1];
  assign buf3_adr = adr_q[2];
  assign buf1_din = din_q[0];
  assign buf2_din = din_q[1];
  assign buf3_din = din_q[2];

endmodule

// File: doc/conv_row_buffer_writer.md
# conv_row_buffer_writer

Fills the three input-row buffers that the convolution front end reads. It accepts a pixel stream with a valid/ready handshake and packs it into `pixels_in_row`-pixel words. Consecutive image rows are distributed round-robin over buffers 1/2/3, and each buffer gets its own sequential write address. It is the write-side counterpart of the row readers: row `y` of every channel lands in buffer `(y mod 3)+1`, in stream order.

## Interface
Parameters:
- `pixels_in_row`, 32, pixels per buffer word (word width = `pixels_in_row*8`).
- `in_pixels`, 4, pixels per input beat; must divide `pixels_in_row`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `ix`, `iy`, `nif`; honoured only in IDLE.
- `ix`, `iy`, `nif`  in  16 each  row width in pixels, rows per channel, channel count. `ix` must be a multiple of `in_pixels`.
- `in_valid`  in  1  input beat valid.
- `in_data`  in  `in_pixels*8`  beat pixels; byte 0 holds the lowest x.
- `in_ready`  out  1  high only in LOAD.
- `buf1_we`, `buf2_we`, `buf3_we`  out  1 each  one-cycle write strobes.
- `buf1_adr`, `buf2_adr`, `buf3_adr`  out  16 each  write addresses.
- `buf1_din`, `buf2_din`, `buf3_din`  out  `pixels_in_row*8` each  write data; byte 0 holds the lowest x of the word.
- `busy`  out  1  high in LOAD and DONE.
- `done`  out  1  one-cycle pulse at the end of the load.

## Operation
- Stream order is channel-major, then row, then x ascending: c = 0..nif-1, y = 0..iy-1, x stepping by `in_pixels`.
- A beat is accepted when `in_valid & in_ready`.
- Per-channel/row/x counters: `x_cnt`, `y_cnt`, `c_cnt`. A pack register holds the word being built; `lane` counts beats within the word, 0..`pixels_in_row/in_pixels`-1.
- Buffer select `sel` runs 0..2. It resets to 0 at start and at each channel start, and advances (mod 3) after each row.
- A word completes on the beat that fills the last lane, or on the last beat of a row. On a row-end completion, the unused upper bytes are zero.
- Words per row = ceil(ix/`pixels_in_row`).
- Write pointers `p1`, `p2`, `p3` start at 0 on `start` and are never reset between channels. Each word written to buffer n uses `pn` as its address, then `pn` increments by 1 and wraps modulo 2^16.
- FSM:
  - IDLE: `start` with ix, iy and nif all nonzero -> LOAD, counters cleared. `start` with any of them zero -> DONE, with no writes.
  - LOAD: return to LOAD after every accepted beat except the last one. The beat with x, y and c all at their final values -> DONE.
  - DONE: `done`=1 for exactly one cycle, `in_ready`=0 -> IDLE.
- A `start` pulse in LOAD or DONE is ignored; `ix`, `iy` and `nif` are used only from their latched copies.
- Reset is asynchronous; its effects, including a mid-operation reset, are listed under Timing.

## Timing
- Reset values: state IDLE; all `we`, `adr`, `din`, `in_ready`, `busy` and `done` are 0; all pointers and counters are 0.
- Reset mid-operation discards the partial word and returns the block to IDLE on the next edge.
- Write outputs are registered. `bufN_we`, `bufN_adr` and `bufN_din` are valid in the cycle after the handshake of the completing beat. At most one `we` is high per cycle. `adr`/`din` hold their values while `we` is low.
- `in_ready` is constant 1 in LOAD. There is no backpressure because at most one word completes per beat. Gaps in `in_valid` simply stall the counters.
- The final word's write strobe is in the same cycle as `done`, i.e. the cycle after the last handshake.
- `in_ready` rises the cycle after `start` and falls the cycle after the last handshake.

## Test plan
- ix=64, iy=3, nif=1, 48 contiguous beats with data = x:
  - buf1 writes adr 0,1 (x 0-31, 32-63); buf2 writes adr 0,1; buf3 writes adr 0,1.
  - `done` coincides with the buf3 adr-1 write.
- ix=40, iy=1, nif=1, 10 beats:
  - buf1 adr0 holds x 0-31; buf1 adr1 holds x 32-39 in bytes 0-7 and zero in bytes 8-31.
  - No writes to buf2 or buf3.
- ix=32, iy=4, nif=2:
  - Row 3 -> buf1 adr1. Channel 1 row 0 -> buf1 adr2; channel 1 row 3 -> buf1 adr3.
  - buf2 and buf3 end at pointer value 2.
- ix=64, iy=3, nif=1 with `in_valid` toggled every other cycle and `start` re-pulsed mid-load:
  - Written words identical to the first test; the extra `start` has no effect.
- Reset asserted after 20 beats of the first test: all outputs 0 asynchronously. A new `start` then restarts from adr 0 in buf1.
- `start` with iy=0: `done` pulse one cycle later, no `we`, `in_ready` never high.
